// File: rtl/sio_pkg.sv
// Shared definitions for the serial word receiver: CRC-4 constants,
// receive FSM state encoding and the CRC-4 helper function.
package sio_pkg;

    localparam int CRC_W = 4;
    localparam logic [CRC_W-1:0] CRC_POLY = 4'h3;  // x^4 + x + 1

    // Widest payload crc4() accepts. Shorter payloads are zero-extended.
    // With a zero initial value, leading zero bits leave the remainder unchanged.
    localparam int CRC_MAX_PW = 60;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        REARM = 2'd2
    } state_e;

    // Computes payload * x^4 mod g. Bits are taken MSB first,
    // the initial value is zero and there is no final XOR.
    function automatic logic [CRC_W-1:0] crc4(input logic [CRC_MAX_PW-1:0] payload);
        logic [CRC_W-1:0] crc;
        logic             fb;
        crc = '0;
        for (int i = CRC_MAX_PW - 1; i >= 0; i--) begin
            fb  = crc[CRC_W-1] ^ payload[i];
            crc = {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
        end
        return crc;
    endfunction

endpackage

// File: rtl/sio_fifo.sv
// Synchronous FIFO with a registered head-of-queue output.
// Pointers are AW+1 bits wide. The extra MSB tells full apart from empty.
// A write to a full FIFO is accepted only when a pop happens in the same cycle.
// A pop from an empty FIFO is ignored.
module sio_fifo #(
    parameter int W  = 12,
    parameter int AW = 3
) (
    input  logic         c,
    input  logic         rn,
    input  logic         wr,
    input  logic [W-1:0] wdata,
    input  logic         rd,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic [AW:0]   rptr_inc;
    logic [W-1:0]  head_q, head_d;
    logic          wr_en;
    logic          rd_en;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rd_en = rd && !empty;
    assign wr_en = wr && (!full || rd_en);
    assign rdata = head_q;

    // Pointer advance and next head value. The head is pre-fetched so rdata is a flop output.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        head_d   = head_q;
        rptr_inc = rptr_q + 1'b1;
        if (wr_en) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (rd_en) begin
            rptr_d = rptr_inc;
            // The slot after the head is the one being written right now, so forward it.
            if (wr_en && (wptr_q == rptr_inc)) begin
                head_d = wdata;
            end else begin
                head_d = mem_q[rptr_inc[AW-1:0]];
            end
        end else if (wr_en && empty) begin
            head_d = wdata;
        end
    end

    // Pointer and head registers. An empty FIFO presents zero after reset.
    always_ff @(posedge c or negedge rn) begin
        if (!rn) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            wptr_q <= '0;
            rptr_q <= '0;
            head_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            head_q <= head_d;
        end
    end

    // Storage array.
    always_ff @(posedge c) begin
        // NOTE: the storage array is not reset. The pointers alone decide which entries are live.
        if (wr_en) begin
            mem_q[wptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/sio_word_rx.sv
// Receiver for words from the oversampled data recovery stage.
// It checks the CRC-4 of each word and queues good payloads in sio_fifo.
// After every word it holds the recovery stage in re-arm reset (dru_r).
// Optional build macro SIO_RX_STATS_EN adds the saturating counters n_good, n_crc and n_ovf.
module sio_word_rx
    import sio_pkg::*;
#(
    parameter int NBO       = 16,
    parameter int AW        = 3,
    parameter int REARM_CYC = 4
) (
    input  logic             c,
    input  logic             rn,
    input  logic [NBO-1:0]   d,
    input  logic             v,
    output logic             dru_r,
    output logic [NBO-5:0]   o_data,
    output logic             o_valid,
    input  logic             o_ready,
    output logic             crc_err,
    output logic             ovf,
    input  logic             clr
`ifdef SIO_RX_STATS_EN
    ,
    output logic [15:0]      n_good,
    output logic [15:0]      n_crc,
    output logic [15:0]      n_ovf
`endif
);

    localparam int PW = NBO - CRC_W;
    localparam logic [3:0] REARM_INIT = 4'(REARM_CYC);

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [NBO-1:0]  word_q, word_d;
    logic            dru_r_q, dru_r_d;
    logic            crc_err_q, crc_err_d;
    logic            ovf_q, ovf_d;

    logic [CRC_W-1:0] crc_calc;
    logic             fifo_wr;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             crc_bad;
    logic             ovf_ev;
    logic             wr_ok;

    assign crc_calc = crc4(CRC_MAX_PW'(word_q[NBO-1:CRC_W]));
    assign o_valid  = !fifo_empty;
    assign pop      = o_valid && o_ready;
    assign wr_ok    = fifo_wr && (!fifo_full || pop);
    assign dru_r    = dru_r_q;
    assign crc_err  = crc_err_q;
    assign ovf      = ovf_q;

    sio_fifo #(
        .W  (PW),
        .AW (AW)
    ) u_fifo (
        .c     (c),
        .rn    (rn),
        .wr    (fifo_wr),
        .wdata (word_q[NBO-1:CRC_W]),
        .rd    (pop),
        .rdata (o_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Receive FSM: latch a word, check its CRC, then hold the recovery stage in re-arm.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        fifo_wr = 1'b0;
        crc_bad = 1'b0;
        case (state_q)
            IDLE: begin
                if (v) begin
                    word_d  = d;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (crc_calc == word_q[CRC_W-1:0]) begin
                    fifo_wr = 1'b1;
                end else begin
                    crc_bad = 1'b1;
                end
                cnt_d   = REARM_INIT;
                state_d = REARM;
            end
            REARM: begin
                if (cnt_q <= 4'd1) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                cnt_d   = REARM_INIT;
                state_d = REARM;
            end
        endcase
    end

    // Overflow and error flags. Re-arm is driven low only while idle,
    // so a packet in progress is never aborted.
    always_comb begin
        // A word is lost if it arrives outside IDLE, or is checked good while the FIFO is full and not popping.
        ovf_ev    = (v && (state_q != IDLE)) || (fifo_wr && fifo_full && !pop);
        dru_r_d   = (state_d != IDLE);
        crc_err_d = crc_bad;
        ovf_d     = ovf_q;
        if (clr) begin
            ovf_d = 1'b0;
        end
        if (ovf_ev) begin
            ovf_d = 1'b1;
        end
    end

    // FSM and flag registers. Reset parks the FSM in REARM with dru_r high.
    always_ff @(posedge c or negedge rn) begin
        if (!rn) begin
            state_q   <= REARM;
            cnt_q     <= REARM_INIT;
            word_q    <= '0;
            dru_r_q   <= 1'b1;
            crc_err_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            word_q    <= word_d;
            dru_r_q   <= dru_r_d;
            crc_err_q <= crc_err_d;
            ovf_q     <= ovf_d;
        end
    end

`ifdef SIO_RX_STATS_EN
    logic [15:0] n_good_q, n_good_d;
    logic [15:0] n_crc_q,  n_crc_d;
    logic [15:0] n_ovf_q,  n_ovf_d;

    assign n_good = n_good_q;
    assign n_crc  = n_crc_q;
    assign n_ovf  = n_ovf_q;

    // Saturating event counters. clr takes priority over an increment in the same cycle.
    always_comb begin
        n_good_d = n_good_q;
        n_crc_d  = n_crc_q;
        n_ovf_d  = n_ovf_q;
        if (clr) begin
            n_good_d = '0;
            n_crc_d  = '0;
            n_ovf_d  = '0;
        end else begin
            if (wr_ok   && (n_good_q != 16'hFFFF)) n_good_d = n_good_q + 16'd1;
            if (crc_bad && (n_crc_q  != 16'hFFFF)) n_crc_d  = n_crc_q  + 16'd1;
            if (ovf_ev  && (n_ovf_q  != 16'hFFFF)) n_ovf_d  = n_ovf_q  + 16'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge c or negedge rn) begin
        if (!rn) begin
            n_good_q <= '0;
            n_crc_q  <= '0;
            n_ovf_q  <= '0;
        end else begin
            n_good_q <= n_good_d;
            n_crc_q  <= n_crc_d;
            n_ovf_q  <= n_ovf_d;
        end
    end
`else
    // Accepted-write strobe only feeds the counters.
    logic unused_wr_ok;
    assign unused_wr_ok = wr_ok;
`endif

endmodule

// File: tb/tb_sio_word_rx.sv
// Directed testbench for sio_word_rx with default parameters
// (NBO=16, AW=3, REARM_CYC=4). Inputs are driven and outputs sampled on the falling clock edge.
// Counter checks are compiled in when SIO_RX_STATS_EN is defined.
module tb_sio_word_rx;

    logic        c = 1'b0;
    logic        rn = 1'b0;
    logic [15:0] d = '0;
    logic        v = 1'b0;
    logic        o_ready = 1'b0;
    logic        clr = 1'b0;
    logic        dru_r;
    logic [11:0] o_data;
    logic        o_valid;
    logic        crc_err;
    logic        ovf;
`ifdef SIO_RX_STATS_EN
    logic [15:0] n_good, n_crc, n_ovf;
`endif

    int total = 0;
    int bad   = 0;

    always #5 c = ~c;

    sio_word_rx #(
        .NBO       (16),
        .AW        (3),
        .REARM_CYC (4)
    ) dut (
        .c       (c),
        .rn      (rn),
        .d       (d),
        .v       (v),
        .dru_r   (dru_r),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .crc_err (crc_err),
        .ovf     (ovf),
        .clr     (clr)
`ifdef SIO_RX_STATS_EN
        ,
        .n_good  (n_good),
        .n_crc   (n_crc),
        .n_ovf   (n_ovf)
`endif
    );

    // Waits (bounded) for the receiver to return to idle; call at a falling edge.
    task automatic wait_idle();
        int n = 0;
        while (dru_r !== 1'b0 && n < 50) begin
            @(negedge c);
            n++;
        end
        if (dru_r !== 1'b0) begin
            total++; bad++;
            $display("FAIL wait_idle: dru_r=%b after %0d cycles, required 0", dru_r, n);
        end
    endtask

    // Pulses v with word w once idle; returns at the falling edge after the latch edge.
    task automatic send_word(input logic [15:0] w);
        wait_idle();
        d = w;
        v = 1'b1;
        @(negedge c);
        v = 1'b0;
    endtask

    task automatic test_reset();
        int hi;
        @(negedge c); @(negedge c); @(negedge c);
        total++; if (dru_r !== 1'b1)     begin bad++; $display("FAIL rst_dru_r: got %b required 1", dru_r); end
        total++; if (o_valid !== 1'b0)   begin bad++; $display("FAIL rst_o_valid: got %b required 0", o_valid); end
        total++; if (o_data !== 12'h000) begin bad++; $display("FAIL rst_o_data: got %h required 000", o_data); end
        total++; if (ovf !== 1'b0)       begin bad++; $display("FAIL rst_ovf: got %b required 0", ovf); end
        total++; if (crc_err !== 1'b0)   begin bad++; $display("FAIL rst_crc_err: got %b required 0", crc_err); end
`ifdef SIO_RX_STATS_EN
        total++; if (n_good !== 16'd0)   begin bad++; $display("FAIL rst_n_good: got %0d required 0", n_good); end
`endif
        rn = 1'b1;
        hi = 0;
        while (dru_r === 1'b1 && hi < 20) begin
            hi++;
            @(negedge c);
        end
        total++; if (hi !== 4)           begin bad++; $display("FAIL rst_dru_r_len: got %0d cycles required 4", hi); end
        total++; if (o_valid !== 1'b0)   begin bad++; $display("FAIL rst_idle_o_valid: got %b required 0", o_valid); end
    endtask

    task automatic test_good_word();
        int hi;
        send_word(16'h0013);
        total++; if (o_valid !== 1'b0)   begin bad++; $display("FAIL good_o_valid_early: got %b required 0", o_valid); end
        total++; if (dru_r !== 1'b1)     begin bad++; $display("FAIL good_dru_r_rise: got %b required 1", dru_r); end
        @(negedge c);
        total++; if (o_valid !== 1'b1)   begin bad++; $display("FAIL good_o_valid: got %b required 1", o_valid); end
        total++; if (o_data !== 12'h001) begin bad++; $display("FAIL good_o_data: got %h required 001", o_data); end
        total++; if (crc_err !== 1'b0)   begin bad++; $display("FAIL good_crc_err: got %b required 0", crc_err); end
        hi = 2;
        @(negedge c);
        while (dru_r === 1'b1 && hi < 20) begin
            hi++;
            @(negedge c);
        end
        total++; if (hi !== 5)           begin bad++; $display("FAIL good_dru_r_len: got %0d cycles required 5", hi); end
        o_ready = 1'b1;
        @(negedge c);
        o_ready = 1'b0;
        total++; if (o_valid !== 1'b0)   begin bad++; $display("FAIL good_pop_empty: got %b required 0", o_valid); end
    endtask

    task automatic test_crc_error();
        send_word(16'h0027);
        total++; if (crc_err !== 1'b0)   begin bad++; $display("FAIL crc_err_early: got %b required 0", crc_err); end
        @(negedge c);
        total++; if (crc_err !== 1'b1)   begin bad++; $display("FAIL crc_err_pulse: got %b required 1", crc_err); end
        total++; if (o_valid !== 1'b0)   begin bad++; $display("FAIL crc_no_write: got %b required 0", o_valid); end
        @(negedge c);
        total++; if (crc_err !== 1'b0)   begin bad++; $display("FAIL crc_err_len: got %b required 0", crc_err); end
        total++; if (o_valid !== 1'b0)   begin bad++; $display("FAIL crc_no_write_late: got %b required 0", o_valid); end
`ifdef SIO_RX_STATS_EN
        total++; if (n_crc !== 16'd1)    begin bad++; $display("FAIL crc_n_crc: got %0d required 1", n_crc); end
`endif
    endtask

    task automatic test_overflow();
        o_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send_word(16'h0000);
        end
        @(negedge c);
        total++; if (ovf !== 1'b0)       begin bad++; $display("FAIL ovf_after8: got %b required 0", ovf); end
        total++; if (o_valid !== 1'b1)   begin bad++; $display("FAIL ovf_valid8: got %b required 1", o_valid); end
        send_word(16'h0000);
        @(negedge c);
        total++; if (ovf !== 1'b1)       begin bad++; $display("FAIL ovf_after9: got %b required 1", ovf); end
`ifdef SIO_RX_STATS_EN
        total++; if (n_ovf !== 16'd1)    begin bad++; $display("FAIL ovf_n_ovf: got %0d required 1", n_ovf); end
        total++; if (n_good !== 16'd9)   begin bad++; $display("FAIL ovf_n_good: got %0d required 9", n_good); end
`endif
        wait_idle();
        clr = 1'b1;
        @(negedge c);
        clr = 1'b0;
        total++; if (ovf !== 1'b0)       begin bad++; $display("FAIL ovf_clr: got %b required 0", ovf); end
    endtask

    task automatic test_full_pop();
        logic [11:0] got [16];
        int          n;
        logic [11:0] exp;
        send_word(16'h0013);
        o_ready = 1'b1;
        @(negedge c);
        o_ready = 1'b0;
        total++; if (ovf !== 1'b0)       begin bad++; $display("FAIL fullpop_ovf: got %b required 0", ovf); end
        wait_idle();
        n = 0;
        o_ready = 1'b1;
        while (o_valid === 1'b1 && n < 16) begin
            got[n] = o_data;
            n++;
            @(negedge c);
        end
        o_ready = 1'b0;
        total++; if (n !== 8)            begin bad++; $display("FAIL fullpop_count: got %0d required 8", n); end
        for (int i = 0; i < n; i++) begin
            exp = (i == 7) ? 12'h001 : 12'h000;
            total++;
            if (got[i] !== exp) begin
                bad++; $display("FAIL fullpop_data[%0d]: got %h required %h", i, got[i], exp);
            end
        end
    endtask

    task automatic test_busy_and_reset();
        total++; if (ovf !== 1'b0)       begin bad++; $display("FAIL busy_ovf_pre: got %b required 0", ovf); end
        send_word(16'h0013);
        @(negedge c);
        d = 16'h0026;
        v = 1'b1;
        @(negedge c);
        v = 1'b0;
        total++; if (ovf !== 1'b1)       begin bad++; $display("FAIL busy_ovf: got %b required 1", ovf); end
        wait_idle();
        total++; if (o_data !== 12'h001) begin bad++; $display("FAIL busy_head: got %h required 001", o_data); end
        send_word(16'h0026);
        send_word(16'h0000);
        @(negedge c);
        total++; if (o_valid !== 1'b1)   begin bad++; $display("FAIL busy_queued: got %b required 1", o_valid); end
        rn = 1'b0;
        #1;
        total++; if (o_valid !== 1'b0)   begin bad++; $display("FAIL rst2_o_valid: got %b required 0", o_valid); end
        total++; if (dru_r !== 1'b1)     begin bad++; $display("FAIL rst2_dru_r: got %b required 1", dru_r); end
        total++; if (ovf !== 1'b0)       begin bad++; $display("FAIL rst2_ovf: got %b required 0", ovf); end
        @(negedge c);
        rn = 1'b1;
        @(negedge c);
        total++; if (o_valid !== 1'b0)   begin bad++; $display("FAIL rst2_rel_o_valid: got %b required 0", o_valid); end
        total++; if (dru_r !== 1'b1)     begin bad++; $display("FAIL rst2_rel_dru_r: got %b required 1", dru_r); end
    endtask

    initial begin
        test_reset();
        test_good_word();
        test_crc_error();
        test_overflow();
        test_full_pop();
        test_busy_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
